packet_generator: RTL and testbench
===================================

// Module: packet_generator
// PURPOSE
//  Parametrised AXI-Stream test-traffic source feeding the CMAC TX path.
//  Emits packets of a programmable byte length with a correct partial TKEEP on
//  the last beat. Sends a programmable number of packets, or runs until
//  stopped. Payload comes from a selectable pattern: counter, constant or LFSR.
// PARAMETERS
//  DW     512  data width in bits; must be a multiple of 64
//  LEN_W  16   width of cfg_bytes (max packet length 2^LEN_W-1 bytes)
//  CNT_W  32   width of cfg_count and pkts_sent
// PORTS
//  clk              in   1         single clock, all logic rising-edge
//  resetn           in   1         asynchronous, active-low reset
//  start            in   1         level-sampled; launches a run when idle
//  stop             in   1         requests graceful end of run
//  cfg_bytes        in   LEN_W     packet length in bytes; latched on start
//  cfg_count        in   CNT_W     packets per run, 0 = unlimited; latched on start
//  cfg_mode         in   2         0=counter 1=constant 2=LFSR 3=reserved(as 0)
//  cfg_fill         in   32        constant word (mode 1) / LFSR seed (mode 2)
//  busy             out  1         run in progress
//  done             out  1         one-cycle pulse at end of run
//  pkts_sent        out  CNT_W     packets completed in current/last run
//  AXIS_OUT_TDATA   out  DW        stream data
//  AXIS_OUT_TKEEP   out  DW/8      byte enables
//  AXIS_OUT_TLAST   out  1         last beat of packet
//  AXIS_OUT_TVALID  out  1         beat valid
//  AXIS_OUT_TREADY  in   1         downstream ready
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE; busy, done, TVALID, TLAST = 0;
//   TDATA, TKEEP, pkts_sent = 0. Reset mid-packet truncates the packet; no recovery.
//  BPB = DW/8. Beats per packet = ceil(cfg_bytes/BPB).
//  FSM IDLE -> SEND -> IDLE:
//   IDLE: start=1 and stop=0 and cfg_bytes!=0 -> latch cfg_*, clear pkts_sent,
//    zero beat counter, seed LFSR, busy=1, go to SEND.
//    The first beat has TVALID=1 in the next cycle.
//    start with cfg_bytes==0, or start and stop together -> ignored; stay IDLE.
//   SEND: a beat advances only on TVALID&TREADY. While TVALID=1 and TREADY=0,
//    TDATA, TKEEP and TLAST are held stable.
//    Last beat of packet: TLAST=1. TKEEP low (cfg_bytes mod BPB) bits set,
//    or all ones if the remainder is 0. All other beats: TKEEP all ones.
//    On the TLAST handshake, pkts_sent increments (wraps at 2^CNT_W).
//    Run ends when pkts_sent reaches cfg_count (cfg_count!=0) or a stop is
//    pending; otherwise the next packet starts with no idle cycle.
//   End of run: the cycle after the final TLAST handshake, TVALID=0, busy=0,
//    done=1 for exactly one cycle, and state returns to IDLE.
//  stop: sticky request captured in SEND. It never truncates a packet; the
//   current packet completes. stop in IDLE has no effect.
//  start in SEND: ignored; cfg_* changes mid-run: ignored.
//  Payload (every 64-bit lane identical in modes 0 and 2):
//   mode 0: lane = 64-bit beat counter, 0 at run start, +1 per handshake,
//    continuing across packets, wraps at 2^64.
//   mode 1: every 32-bit word = cfg_fill.
//   mode 2: 32-bit Galois LFSR, taps x^32+x^22+x^2+x+1. Seed = cfg_fill, or 1
//    if cfg_fill==0. Advances once per handshake. Lane = {lfsr, ~lfsr}.
//  Bytes beyond cfg_bytes on the last beat carry the pattern unchanged; only
//   TKEEP masks them.
//  All outputs are registered; no combinational path from TREADY to TVALID.
// TESTING
//  T1 DW=512, cfg_bytes=64, count=3, mode 0, TREADY=1 -> 3 beats, each TLAST=1,
//     TKEEP all ones, lane data 0,1,2, done one cycle after 3rd beat, pkts_sent=3.
//  T2 cfg_bytes=130, count=2 -> 3 beats/pkt; last beat TKEEP=64'h3, TLAST only
//     on beats 3 and 6, back-to-back packets with no gap.
//  T3 random TREADY (50%), mode 2, seed 0 -> first lane {32'h1, 32'hFFFFFFFE},
//     data stable on every stall cycle, LFSR advances only on handshakes.
//  T4 count=0, mode 1 fill=32'hA5A5A5A5; assert stop mid-packet 2 -> packet 2
//     completes, done pulses, pkts_sent=2, stream idles.
//  T5 start with cfg_bytes=0, then start+stop together -> no TVALID, busy=0, no done.
//  T6 resetn low mid-packet with TREADY=0 -> TVALID, busy =0 immediately; new
//     start afterwards begins at counter 0.

Source files
------------

// File: rtl/packet_generator_if.sv
// AXI-Stream bundle carried between the packet generator and its sink.
interface packet_generator_if #(
    parameter int DW = 512
) ();
    logic [DW-1:0]   TDATA;
    logic [DW/8-1:0] TKEEP;
    logic            TLAST;
    logic            TVALID;
    logic            TREADY;

    modport master (
        output TDATA,
        output TKEEP,
        output TLAST,
        output TVALID,
        input  TREADY
    );

    modport slave (
        input  TDATA,
        input  TKEEP,
        input  TLAST,
        input  TVALID,
        output TREADY
    );
endinterface

// File: rtl/packet_generator.sv
// AXI-Stream test-traffic source: fixed-length packets, counter/constant/LFSR
// payload, partial TKEEP on the last beat, counted or open-ended runs.
// resetn is asserted asynchronously; its release is expected to be
// synchronised to clk outside this block.
module packet_generator #(
    parameter int DW    = 512,
    parameter int LEN_W = 16,
    parameter int CNT_W = 32
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     start,
    input  logic                     stop,
    input  logic [LEN_W-1:0]         cfg_bytes,
    input  logic [CNT_W-1:0]         cfg_count,
    input  logic [1:0]               cfg_mode,
    input  logic [31:0]              cfg_fill,
    output logic                     busy,
    output logic                     done,
    output logic [CNT_W-1:0]         pkts_sent,
    packet_generator_if.master       axis_out
);

    localparam int BPB   = DW / 8;
    localparam int LANES = DW / 64;
    localparam logic [LEN_W-1:0] BPB_L = LEN_W'(BPB);
    localparam logic [CNT_W-1:0] ONE_C = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t            state_q,     state_d;
    logic              busy_q,      busy_d;
    logic              done_q,      done_d;
    logic [CNT_W-1:0]  pkts_q,      pkts_d;
    logic              tvalid_q,    tvalid_d;
    logic              tlast_q,     tlast_d;
    logic [DW-1:0]     tdata_q,     tdata_d;
    logic [BPB-1:0]    tkeep_q,     tkeep_d;
    logic [LEN_W-1:0]  rem_q,       rem_d;       // bytes left in packet, current beat included
    logic [63:0]       cnt_q,       cnt_d;       // beat counter for the current beat
    logic [31:0]       lfsr_q,      lfsr_d;      // LFSR value for the current beat
    logic              stop_pend_q, stop_pend_d;
    logic [LEN_W-1:0]  bytes_q,     bytes_d;
    logic [CNT_W-1:0]  count_q,     count_d;
    logic [1:0]        mode_q,      mode_d;
    logic [31:0]       fill_q,      fill_d;
    logic              ship_s;
    logic              load_s;

    // One Galois step of x^32+x^22+x^2+x+1 (right-shifting form).
    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        lfsr_step = (l >> 1) ^ (l[0] ? 32'h8020_0003 : 32'h0000_0000);
    endfunction

    // Byte-enable mask for a beat with rem bytes still to send.
    function automatic logic [BPB-1:0] keep_for(input logic [LEN_W-1:0] rem);
        logic [BPB-1:0] k;
        for (int i = 0; i < BPB; i++) begin
            k[i] = (i < int'(rem));
        end
        keep_for = k;
    endfunction

    // Full-width payload for one beat; modes 0/3 and 2 repeat a 64-bit lane.
    function automatic logic [DW-1:0] pattern(input logic [1:0]  mode,
                                              input logic [31:0] fill,
                                              input logic [63:0] cnt,
                                              input logic [31:0] lfsr);
        logic [63:0]   lane;
        logic [DW-1:0] d;
        case (mode)
            2'd1:    lane = {fill, fill};
            2'd2:    lane = {lfsr, ~lfsr};
            default: lane = cnt;
        endcase
        for (int i = 0; i < LANES; i++) begin
            d[i*64 +: 64] = lane;
        end
        pattern = d;
    endfunction

    assign ship_s = tvalid_q & axis_out.TREADY;

    // Next-state and next-output logic for the IDLE/SEND sequencer.
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pkts_d      = pkts_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        tdata_d     = tdata_q;
        tkeep_d     = tkeep_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        lfsr_d      = lfsr_q;
        stop_pend_d = stop_pend_q;
        bytes_d     = bytes_q;
        count_d     = count_q;
        mode_d      = mode_q;
        fill_d      = fill_q;
        load_s      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !stop && (cfg_bytes != {LEN_W{1'b0}})) begin
                    bytes_d     = cfg_bytes;
                    count_d     = cfg_count;
                    mode_d      = cfg_mode;
                    fill_d      = cfg_fill;
                    pkts_d      = {CNT_W{1'b0}};
                    cnt_d       = 64'd0;
                    lfsr_d      = (cfg_fill == 32'h0000_0000) ? 32'h0000_0001 : cfg_fill;
                    rem_d       = cfg_bytes;
                    stop_pend_d = 1'b0;
                    busy_d      = 1'b1;
                    tvalid_d    = 1'b1;
                    load_s      = 1'b1;
                    state_d     = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                stop_pend_d = stop_pend_q | stop;
                if (ship_s) begin
                    cnt_d  = cnt_q + 64'd1;
                    lfsr_d = lfsr_step(lfsr_q);
                    if (tlast_q) begin
                        pkts_d = pkts_q + ONE_C;
                        if (((count_q != {CNT_W{1'b0}}) && (pkts_d == count_q)) || stop_pend_d) begin
                            state_d  = ST_IDLE;
                            busy_d   = 1'b0;
                            done_d   = 1'b1;
                            tvalid_d = 1'b0;
                            tlast_d  = 1'b0;
                        end else begin
                            rem_d  = bytes_q;
                            load_s = 1'b1;
                        end
                    end else begin
                        rem_d  = rem_q - BPB_L;
                        load_s = 1'b1;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                busy_d   = 1'b0;
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
            end
        endcase

        if (load_s) begin
            tdata_d = pattern(mode_d, fill_d, cnt_d, lfsr_d);
            tkeep_d = keep_for(rem_d);
            tlast_d = (rem_d <= BPB_L);
        end else begin
            tdata_d = tdata_d;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pkts_q      <= {CNT_W{1'b0}};
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tdata_q     <= {DW{1'b0}};
            tkeep_q     <= {BPB{1'b0}};
            rem_q       <= {LEN_W{1'b0}};
            cnt_q       <= 64'd0;
            lfsr_q      <= 32'h0000_0001;
            stop_pend_q <= 1'b0;
            bytes_q     <= {LEN_W{1'b0}};
            count_q     <= {CNT_W{1'b0}};
            mode_q      <= 2'd0;
            fill_q      <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pkts_q      <= pkts_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            tdata_q     <= tdata_d;
            tkeep_q     <= tkeep_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            lfsr_q      <= lfsr_d;
            stop_pend_q <= stop_pend_d;
            bytes_q     <= bytes_d;
            count_q     <= count_d;
            mode_q      <= mode_d;
            fill_q      <= fill_d;
        end
    end

    assign busy            = busy_q;
    assign done            = done_q;
    assign pkts_sent       = pkts_q;
    assign axis_out.TDATA  = tdata_q;
    assign axis_out.TKEEP  = tkeep_q;
    assign axis_out.TLAST  = tlast_q;
    assign axis_out.TVALID = tvalid_q;

endmodule

// File: tb/tb_packet_generator.sv
// Self-checking bench for packet_generator: packet-level reference model,
// per-cycle compare at negedge, directed scenarios plus randomized runs.
module tb_packet_generator;
    localparam int DW    = 512;
    localparam int LEN_W = 16;
    localparam int CNT_W = 32;
    localparam int BPB   = DW / 8;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic [LEN_W-1:0] cfg_bytes = '0;
    logic [CNT_W-1:0] cfg_count = '0;
    logic [1:0]       cfg_mode = 2'd0;
    logic [31:0]      cfg_fill = 32'h0;
    logic             busy, done;
    logic [CNT_W-1:0] pkts_sent;

    packet_generator_if #(.DW(DW)) axis ();

    packet_generator #(.DW(DW), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .stop      (stop),
        .cfg_bytes (cfg_bytes),
        .cfg_count (cfg_count),
        .cfg_mode  (cfg_mode),
        .cfg_fill  (cfg_fill),
        .busy      (busy),
        .done      (done),
        .pkts_sent (pkts_sent),
        .axis_out  (axis)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_w(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
    bit          m_stop = 1'b0;
    logic [31:0] m_pkts = 32'h0;
    logic [63:0] m_beat = 64'h0;
    logic [31:0] m_lfsr = 32'h1;
    int          m_idx = 0;
    int          m_bytes = 0;
    logic [31:0] m_count = 32'h0;
    logic [1:0]  m_mode = 2'd0;
    logic [31:0] m_fill = 32'h0;

    logic [63:0] log_lane [0:255];
    logic [63:0] log_keep [0:255];
    logic        log_last [0:255];
    int          hs_n = 0;

    function automatic logic [31:0] lfsr_next(input logic [31:0] l);
        logic [31:0] r;
        r = l >> 1;
        if (l[0]) r = r ^ 32'h8020_0003;
        return r;
    endfunction

    function automatic logic [DW-1:0] exp_data(input logic [1:0] mode, input logic [31:0] fill,
                                               input logic [63:0] beat, input logic [31:0] lf);
        logic [63:0]   lane;
        logic [DW-1:0] d;
        if (mode == 2'd1)      lane = {fill, fill};
        else if (mode == 2'd2) lane = {lf, ~lf};
        else                   lane = beat;
        for (int i = 0; i < DW / 64; i++) d[i*64 +: 64] = lane;
        return d;
    endfunction

    // Per-cycle compare and model advance for the upcoming clock edge.
    always @(negedge clk) begin
        int nb;
        int kept;
        logic [63:0] ek;
        bit last;
        if (!resetn) begin
            m_busy = 1'b0; m_done = 1'b0; m_pkts = 32'h0;
            chk("rst_busy", 64'(busy), 64'h0);
            chk("rst_tvalid", 64'(axis.TVALID), 64'h0);
            chk("rst_pkts", 64'(pkts_sent), 64'h0);
        end else begin
            nb   = (m_bytes + BPB - 1) / BPB;
            kept = m_bytes - m_idx * BPB;
            ek   = (kept >= BPB) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'h1 << kept) - 64'h1);
            last = (m_idx == nb - 1);
            chk("busy", 64'(busy), 64'(m_busy));
            chk("done", 64'(done), 64'(m_done));
            chk("tvalid", 64'(axis.TVALID), 64'(m_busy));
            chk("pkts_sent", 64'(pkts_sent), 64'(m_pkts));
            if (m_busy) begin
                chk_w("tdata", axis.TDATA, exp_data(m_mode, m_fill, m_beat, m_lfsr));
                chk("tkeep", 64'(axis.TKEEP), ek);
                chk("tlast", 64'(axis.TLAST), 64'(last));
            end
            m_done = 1'b0;
            if (m_busy) begin
                m_stop = m_stop | stop;
                if (axis.TREADY) begin
                    if (hs_n < 256) begin
                        log_lane[hs_n] = axis.TDATA[63:0];
                        log_keep[hs_n] = 64'(axis.TKEEP);
                        log_last[hs_n] = axis.TLAST;
                    end
                    hs_n++;
                    m_beat = m_beat + 64'h1;
                    m_lfsr = lfsr_next(m_lfsr);
                    if (last) begin
                        m_pkts = m_pkts + 32'h1;
                        m_idx  = 0;
                        if (((m_count != 32'h0) && (m_pkts == m_count)) || m_stop) begin
                            m_busy = 1'b0;
                            m_done = 1'b1;
                        end
                    end else begin
                        m_idx++;
                    end
                end
            end else if (start && !stop && (cfg_bytes != 16'h0)) begin
                m_busy  = 1'b1;
                m_stop  = 1'b0;
                m_pkts  = 32'h0;
                m_beat  = 64'h0;
                m_idx   = 0;
                m_bytes = int'(cfg_bytes);
                m_count = cfg_count;
                m_mode  = cfg_mode;
                m_fill  = cfg_fill;
                m_lfsr  = (cfg_fill == 32'h0) ? 32'h1 : cfg_fill;
            end
        end
    end

    // ---------------- stimulus ----------------
    bit rand_rdy = 1'b0;
    bit scramble = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) axis.TREADY = 1'($urandom_range(0, 1));
        if (scramble && busy) begin
            cfg_bytes = 16'($urandom);
            cfg_count = $urandom;
            cfg_mode  = 2'($urandom);
            cfg_fill  = $urandom;
        end
    endtask

    task automatic launch(input int bytes, input int count, input int mode, input logic [31:0] fill);
        cfg_bytes = 16'(bytes);
        cfg_count = 32'(count);
        cfg_mode  = 2'(mode);
        cfg_fill  = fill;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input int stop_at);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            stop = (i == stop_at);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        stop = 1'b0;
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done within %0d cycles", budget);
        end
    endtask

    initial begin
        int ok;
        axis.TREADY = 1'b0;
        repeat (3) tick();
        chk("reset_busy", 64'(busy), 64'h0);
        chk("reset_done", 64'(done), 64'h0);
        chk("reset_tlast", 64'(axis.TLAST), 64'h0);
        chk_w("reset_tdata", axis.TDATA, '0);
        chk("reset_tkeep", 64'(axis.TKEEP), 64'h0);
        resetn = 1'b1;
        tick();

        // T1: single-beat packets, counter payload
        axis.TREADY = 1'b1;
        hs_n = 0;
        launch(64, 3, 0, 32'h0);
        wait_done(50, -1);
        chk("t1_beats", 64'(hs_n), 64'd3);
        chk("t1_lane0", log_lane[0], 64'd0);
        chk("t1_lane1", log_lane[1], 64'd1);
        chk("t1_lane2", log_lane[2], 64'd2);
        chk("t1_last0", 64'(log_last[0]), 64'h1);
        chk("t1_keep2", log_keep[2], 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t1_pkts", 64'(pkts_sent), 64'd3);
        tick();
        chk("t1_done_once", 64'(done), 64'h0);

        // T2: 130-byte packets, partial last beat
        hs_n = 0;
        launch(130, 2, 0, 32'h0);
        wait_done(50, -1);
        chk("t2_beats", 64'(hs_n), 64'd6);
        chk("t2_keep0", log_keep[0], 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t2_keep2", log_keep[2], 64'h3);
        chk("t2_keep5", log_keep[5], 64'h3);
        chk("t2_last1", 64'(log_last[1]), 64'h0);
        chk("t2_last2", 64'(log_last[2]), 64'h1);
        chk("t2_last5", 64'(log_last[5]), 64'h1);
        chk("t2_lane3", log_lane[3], 64'd3);

        // T3: LFSR payload, seed 0, random backpressure
        rand_rdy = 1'b1;
        hs_n = 0;
        launch(200, 2, 2, 32'h0);
        wait_done(400, -1);
        chk("t3_lane0", log_lane[0], 64'h0000_0001_FFFF_FFFE);
        chk("t3_lane1", log_lane[1], 64'h8020_0003_7FDF_FFFC);
        rand_rdy = 1'b0;
        axis.TREADY = 1'b1;

        // T4: unlimited run with constant fill, stop during packet 2
        hs_n = 0;
        launch(200, 0, 1, 32'hA5A5_A5A5);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (hs_n >= 5) begin ok = 1; break; end
            tick();
        end
        chk("t4_reach_pkt2", 64'(ok), 64'h1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_done(50, -1);
        chk("t4_pkts", 64'(pkts_sent), 64'd2);
        chk("t4_beats", 64'(hs_n), 64'd8);
        chk("t4_lane7", log_lane[7], 64'hA5A5_A5A5_A5A5_A5A5);
        chk("t4_keep7", log_keep[7], 64'hFF);
        repeat (4) tick();
        chk("t4_idle", 64'(axis.TVALID), 64'h0);

        // T5: zero-length start and start+stop are ignored
        hs_n = 0;
        launch(0, 1, 0, 32'h0);
        repeat (3) tick();
        stop = 1'b1;
        launch(64, 1, 0, 32'h0);
        stop = 1'b0;
        repeat (3) tick();
        chk("t5_busy", 64'(busy), 64'h0);
        chk("t5_beats", 64'(hs_n), 64'd0);

        // T6: reset while stalled mid-packet, then a fresh run
        axis.TREADY = 1'b0;
        launch(256, 0, 0, 32'h0);
        repeat (3) tick();
        resetn = 1'b0;
        #1;
        chk("t6_tvalid", 64'(axis.TVALID), 64'h0);
        chk("t6_busy", 64'(busy), 64'h0);
        repeat (2) tick();
        resetn = 1'b1;
        tick();
        axis.TREADY = 1'b1;
        hs_n = 0;
        launch(64, 1, 0, 32'h0);
        wait_done(20, -1);
        chk("t6_lane0", log_lane[0], 64'd0);
        chk("t6_pkts", 64'(pkts_sent), 64'd1);

        // Randomized runs with backpressure and mid-run config churn
        rand_rdy = 1'b1;
        for (int r = 0; r < 16; r++) begin
            int bytes, cnt, stop_at;
            logic [31:0] fill;
            bytes = $urandom_range(1, 300);
            cnt   = $urandom_range(0, 3);
            fill  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            stop_at = (cnt == 0 || $urandom_range(0, 3) == 0) ? $urandom_range(0, 30) : -1;
            launch(bytes, cnt, $urandom_range(0, 3), fill);
            scramble = 1'b1;
            wait_done(1000, stop_at);
            scramble = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
        end
        rand_rdy = 1'b0;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
